// File: rtl/fxp_add_arbiter_if.sv
// fxp_add_arbiter_if: request/response bundle between requesters, the shared adder and downstream
interface fxp_add_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int WORD_WIDTH = 16
);
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*WORD_WIDTH-1:0] req_op_a;
  logic [NUM_REQ*WORD_WIDTH-1:0] req_op_b;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [WORD_WIDTH-1:0]         rsp_data;
  logic [IW-1:0]                 rsp_id;
  logic                          rsp_ovf;
  modport master (
    output req_valid, req_op_a, req_op_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf
  );
  modport slave (
    input  req_valid, req_op_a, req_op_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf
  );
endinterface

// File: rtl/fxp_add_arbiter.sv
// fxp_add_arbiter: round-robin shared fixed-point adder with one result register; FXP_ADD_ARBITER_SAT_EN enables saturation
module fxp_add_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WORD_WIDTH = 16,
  parameter int FRAC_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  fxp_add_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int W  = WORD_WIDTH;
  if (NUM_REQ < 2 || NUM_REQ > 8 || FRAC_WIDTH >= WORD_WIDTH || FRAC_WIDTH < 0) begin : g_bad_cfg
    $error("fxp_add_arbiter: illegal parameter combination");
  end
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d, gnt;
  logic [IW-1:0]      cand [NUM_REQ];
  logic               found, free, xfer, ovf;
  logic [W-1:0]       a, b, res;
  logic [W:0]         sum;
  logic               rsp_valid_q, rsp_valid_d, rsp_ovf_q, rsp_ovf_d;
  logic [W-1:0]       rsp_data_q, rsp_data_d;
  logic [IW-1:0]      rsp_id_q, rsp_id_d;
  logic [NUM_REQ-1:0] req_ready;
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
    assign cand[k] = IW'((32'(rr_ptr_q) + k) % NUM_REQ);
  end
  // first valid requester at or after rr_ptr; descending scan so the nearest candidate wins
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[cand[k]]) begin
        found = 1'b1;
        gnt   = cand[k];
      end
    end
  end
  assign free = ~rsp_valid_q | bus.rsp_ready;
  assign xfer = found & free & ~rst;
  // one-hot accept for the granted requester only
  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[gnt] = 1'b1;
  end
  assign a   = bus.req_op_a[int'(gnt)*W +: W];
  assign b   = bus.req_op_b[int'(gnt)*W +: W];
  assign sum = {a[W-1], a} + {b[W-1], b};
  assign ovf = sum[W] ^ sum[W-1];
`ifdef FXP_ADD_ARBITER_SAT_EN
  assign res = ovf ? {a[W-1], {(W-1){~a[W-1]}}} : sum[W-1:0];
`else
  assign res = sum[W-1:0];
`endif
  // load result on transfer, drain on downstream accept, advance pointer past the winner
  always_comb begin
    rsp_valid_d = xfer | (rsp_valid_q & ~bus.rsp_ready);
    rsp_data_d  = xfer ? res : rsp_data_q;
    rsp_id_d    = xfer ? gnt : rsp_id_q;
    rsp_ovf_d   = xfer ? ovf : rsp_ovf_q;
    rr_ptr_d    = xfer ? ((gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + IW'(1)) : rr_ptr_q;
  end
  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_ovf_q   <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
endmodule

// File: tb/tb_fxp_add_arbiter.sv
// tb_fxp_add_arbiter: table-driven check of grant order, sums, overflow, stalls and reset
module tb_fxp_add_arbiter;
  typedef struct {
    logic [3:0]  v;
    logic [15:0] a;
    logic [15:0] b;
    logic        rdy;
    logic [3:0]  er;
    logic        erv;
    logic [15:0] ed;
    logic [1:0]  eid;
    logic        eovf;
  } vec_t;
`ifdef FXP_ADD_ARBITER_SAT_EN
  localparam logic [15:0] O1 = 16'h7FFF, O2 = 16'h8000, O3 = 16'h7FFF;
`else
  localparam logic [15:0] O1 = 16'h8100, O2 = 16'h0000, O3 = 16'h8000;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  vec_t tbl [13];
  always #5 clk = ~clk;
  fxp_add_arbiter_if #(.NUM_REQ(4), .WORD_WIDTH(16)) bus ();
  fxp_add_arbiter #(.NUM_REQ(4), .WORD_WIDTH(16), .FRAC_WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  function automatic vec_t mk(logic [3:0] v, logic [15:0] a, logic [15:0] b, logic rdy,
                              logic [3:0] er, logic erv, logic [15:0] ed, logic [1:0] eid, logic eovf);
    vec_t r;
    r.v = v; r.a = a; r.b = b; r.rdy = rdy; r.er = er;
    r.erv = erv; r.ed = ed; r.eid = eid; r.eovf = eovf;
    return r;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  // non-granted slices get random junk so a wrong operand select shows up
  task automatic drive(logic [3:0] v, logic [15:0] a, logic [15:0] b, logic rdy, logic [3:0] er);
    bus.req_valid = v;
    bus.rsp_ready = rdy;
    for (int i = 0; i < 4; i++) begin
      bus.req_op_a[i*16 +: 16] = er[i] ? a : 16'($urandom);
      bus.req_op_b[i*16 +: 16] = er[i] ? b : 16'($urandom);
    end
  endtask
  initial begin
    tbl[0]  = mk(4'b0100, 16'h0180, 16'h0240, 1'b1, 4'b0100, 1'b1, 16'h03C0, 2'd2, 1'b0);
    tbl[1]  = mk(4'b1111, 16'h7F00, 16'h0200, 1'b1, 4'b1000, 1'b1, O1,       2'd3, 1'b1);
    tbl[2]  = mk(4'b1111, 16'hFF00, 16'hFE80, 1'b1, 4'b0001, 1'b1, 16'hFD80, 2'd0, 1'b0);
    tbl[3]  = mk(4'b1111, 16'h0100, 16'h0100, 1'b1, 4'b0010, 1'b1, 16'h0200, 2'd1, 1'b0);
    tbl[4]  = mk(4'b1111, 16'h8000, 16'h8000, 1'b1, 4'b0100, 1'b1, O2,       2'd2, 1'b1);
    tbl[5]  = mk(4'b1111, 16'h0001, 16'hFFFF, 1'b1, 4'b1000, 1'b1, 16'h0000, 2'd3, 1'b0);
    tbl[6]  = mk(4'b1111, 16'h7FFF, 16'h0001, 1'b1, 4'b0001, 1'b1, O3,       2'd0, 1'b1);
    tbl[7]  = mk(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 1'b0);
    tbl[8]  = mk(4'b0001, 16'h0010, 16'h0020, 1'b0, 4'b0001, 1'b1, 16'h0030, 2'd0, 1'b0);
    tbl[9]  = mk(4'b1111, 16'h5555, 16'h1111, 1'b0, 4'b0000, 1'b1, 16'h0030, 2'd0, 1'b0);
    tbl[10] = mk(4'b1111, 16'h5555, 16'h1111, 1'b0, 4'b0000, 1'b1, 16'h0030, 2'd0, 1'b0);
    tbl[11] = mk(4'b1111, 16'h5555, 16'h1111, 1'b0, 4'b0000, 1'b1, 16'h0030, 2'd0, 1'b0);
    tbl[12] = mk(4'b1111, 16'h1234, 16'h0001, 1'b1, 4'b0010, 1'b1, 16'h1235, 2'd1, 1'b0);
    drive(4'b1111, 16'h0001, 16'h0001, 1'b1, 4'b0000);
    #1 chk("ready_in_reset", 32'(bus.req_ready), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_data", 32'(bus.rsp_data), 32'h0);
    chk("rst_id", 32'(bus.rsp_id), 32'h0);
    chk("rst_ovf", 32'(bus.rsp_ovf), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].rdy, tbl[i].er);
      #1 chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].er));
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 32'(bus.rsp_valid), 32'(tbl[i].erv));
      if (tbl[i].erv) begin
        chk($sformatf("v%0d_data", i), 32'(bus.rsp_data), 32'(tbl[i].ed));
        chk($sformatf("v%0d_id", i), 32'(bus.rsp_id), 32'(tbl[i].eid));
        chk($sformatf("v%0d_ovf", i), 32'(bus.rsp_ovf), 32'(tbl[i].eovf));
      end
    end
    rst = 1'b1;
    drive(4'b1111, 16'h0002, 16'h0002, 1'b0, 4'b0000);
    #1 chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(bus.rsp_valid), 32'h0);
    chk("mid_rst_data", 32'(bus.rsp_data), 32'h0);
    rst = 1'b0;
    drive(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000);
    #1 chk("post_rst_idle_ready", 32'(bus.req_ready), 32'h0);
    @(posedge clk); #1;
    chk("post_rst_discard", 32'(bus.rsp_valid), 32'h0);
    drive(4'b1010, 16'h0003, 16'h0004, 1'b1, 4'b0010);
    #1 chk("post_rst_grant", 32'(bus.req_ready), 32'h2);
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(bus.rsp_valid), 32'h1);
    chk("post_rst_data", 32'(bus.rsp_data), 32'h0007);
    chk("post_rst_id", 32'(bus.rsp_id), 32'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
